// File: rtl/lc3b_types.sv
// Shared types for the LC-3b data cache controller: controller state
// encoding and performance counter width.
package lc3b_types;

  localparam int unsigned PERF_CNT_W = 16;

  typedef logic [PERF_CNT_W-1:0] perf_cnt_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } dcache_ctrl_state_t;

endpackage

// File: rtl/dcache_perf_counter.sv
// Saturating performance counter: counts cycles with inc high and sticks
// at all-ones instead of wrapping.
module dcache_perf_counter
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      inc,
  output perf_cnt_t count
);

  // Increment on enable, hold once saturated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      count <= count + perf_cnt_t'(1);
    end
  end

endmodule

// File: rtl/dcache_control.sv
// Data cache controller FSM (IDLE / WRITEBACK / ALLOCATE) for a write-back,
// write-allocate cache. Hits complete combinationally in IDLE; misses write
// back a dirty victim if needed, fill the line, then re-run the request in
// IDLE where it completes as a hit.
// Optional hit/miss performance counters are built when the macro
// DCACHE_PERF_COUNTERS_EN is defined; otherwise both counter ports read 0.
module dcache_control
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      reset_n,
  // CPU side
  input  logic      mem_read,
  input  logic      mem_write,
  output logic      mem_resp,
  // Datapath / set storage
  input  logic      hit,
  input  logic      line_dirty,
  output logic      set_load,
  output logic      write_type,
  output logic      data_sel,
  // Physical memory
  output logic      pmem_read,
  output logic      pmem_write,
  output logic      pmem_addr_sel,
  input  logic      pmem_resp,
  // Performance counters
  output perf_cnt_t hit_count,
  output perf_cnt_t miss_count
);

  dcache_ctrl_state_t state;

  logic req;
  logic is_write;
  logic miss_start;

  // A simultaneous read and write is handled as a write.
  assign req        = mem_read | mem_write;
  assign is_write   = mem_write;
  assign miss_start = reset_n && (state == IDLE) && req && !hit;

  // State transitions; a reset mid-transfer simply abandons it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !hit) begin
            state <= line_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control outputs decoded from state and inputs. They are forced low
  // while reset is asserted so no strobe can leak during reset.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    mem_resp      = 1'b0;
    set_load      = 1'b0;
    write_type    = 1'b0;
    data_sel      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            if (is_write) begin
              set_load   = 1'b1;
              write_type = 1'b1;
              data_sel   = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            set_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_PERF_COUNTERS_EN
  dcache_perf_counter u_hit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (mem_resp),
    .count   (hit_count)
  );

  dcache_perf_counter u_miss_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (miss_start),
    .count   (miss_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
